// File: rtl/encoder_8b10b_if.sv
// Symbol-side bus of the 8b/10b transmit encoder: byte handshake in, 10-bit symbol out.
// Port names keep the i_/o_ direction prefixes of the original block.
interface encoder_8b10b_if;
   logic       i_en;
   logic [7:0] i_8b;
   logic       i_ctrl;
   logic       i_valid;
   logic       o_ready;
   logic [9:0] o_10b;
   logic       o_valid;
   logic       o_disp;
   logic       o_idle;
   logic       o_code_err;

   modport master (
      output i_en, i_8b, i_ctrl, i_valid,
      input  o_ready, o_10b, o_valid, o_disp, o_idle, o_code_err
   );

   modport slave (
      input  i_en, i_8b, i_ctrl, i_valid,
      output o_ready, o_10b, o_valid, o_disp, o_idle, o_code_err
   );
endinterface

// File: rtl/encoder_8b10b.sv
// Registered 8b/10b transmit encoder: one-entry holding register, running disparity,
// automatic IDLE_K insertion when nothing is pending and for illegal K requests.
module encoder_8b10b #(
   parameter logic [7:0] IDLE_K = 8'hBC
) (
   input logic          i_clk,
   input logic          i_aresetn,
   encoder_8b10b_if.slave bus
);

   typedef struct packed {
      logic [7:0] data;
      logic       ctrl;
   } entry_t;

   // 5b/6b codes in abcdei order (bit 5 = a), RD- column; RD+ is the complement where it differs.
   localparam logic [31:0][5:0] D6 = {
      6'b101011, 6'b011110, 6'b101110, 6'b001110, 6'b110110, 6'b010110, 6'b100110, 6'b110011,
      6'b111010, 6'b011010, 6'b101010, 6'b001011, 6'b110010, 6'b010011, 6'b100011, 6'b011011,
      6'b010111, 6'b011100, 6'b101100, 6'b001101, 6'b110100, 6'b010101, 6'b100101, 6'b111001,
      6'b111000, 6'b011001, 6'b101001, 6'b110101, 6'b110001, 6'b101101, 6'b011101, 6'b100111
   };
   // 3b/4b codes in fghj order (bit 3 = f), column used when RD after the 6b block is RD-.
   localparam logic [7:0][3:0] D4 = {
      4'b1110, 4'b0110, 4'b1010, 4'b1101, 4'b1100, 4'b0101, 4'b1001, 4'b1011
   };
   localparam logic [7:0][3:0] K4 = {
      4'b0111, 4'b1001, 4'b0101, 4'b1101, 4'b1100, 4'b1010, 4'b0110, 4'b1011
   };

   entry_t     hold;
   entry_t     sel;
   logic       full;
   logic       rd;
   logic       ready;
   logic       accept;
   logic       sel_idle;
   logic       sel_err;
   logic [4:0] x;
   logic [2:0] y;
   logic [5:0] c6;
   logic [5:0] s6;
   logic [3:0] c4;
   logic [3:0] s4;
   logic       inv6;
   logic       inv4;
   logic       rd6;
   logic       rd_nxt;
   logic       alt7;
   logic [9:0] sym;

   function automatic logic k_ok(input logic [7:0] b);
      return (b[4:0] == 5'd28) ||
             (b[7:5] == 3'b111 && (b[4:0] == 5'd23 || b[4:0] == 5'd27 ||
                                   b[4:0] == 5'd29 || b[4:0] == 5'd30));
   endfunction

   assign ready       = !full || bus.i_en;
   assign accept      = bus.i_valid && ready;
   assign bus.o_ready = ready;
   assign bus.o_disp  = rd;

   always_comb begin
      sel.data = IDLE_K;
      sel.ctrl = 1'b1;
      sel_idle = 1'b1;
      sel_err  = 1'b0;
      if (full) begin
         sel_idle = 1'b0;
         if (hold.ctrl && !k_ok(hold.data)) sel_err = 1'b1;
         else                               sel     = hold;
      end

      x  = sel.data[4:0];
      y  = sel.data[7:5];
      c6 = (sel.ctrl && x == 5'd28) ? 6'b001111 : D6[x];
      // D.7 is balanced but still has distinct RD-/RD+ forms
      inv6 = ($countones(c6) != 3) || (!sel.ctrl && x == 5'd7);
      s6   = (rd && inv6) ? ~c6 : c6;
      rd6  = rd ^ ($countones(c6) != 3);

      alt7 = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                 : (x == 5'd17 || x == 5'd18 || x == 5'd20);
      if (sel.ctrl) begin
         c4   = K4[y];
         inv4 = 1'b1;
      end else if (y == 3'd7) begin
         c4   = alt7 ? 4'b0111 : 4'b1110;
         inv4 = 1'b1;
      end else begin
         c4   = D4[y];
         inv4 = (y == 3'd0 || y == 3'd3 || y == 3'd4);
      end
      s4     = (rd6 && inv4) ? ~c4 : c4;
      rd_nxt = rd6 ^ ($countones(c4) != 2);

      // a lands on bit 0 and j on bit 9, so both sub-blocks are bit-reversed
      sym = {s4[0], s4[1], s4[2], s4[3], s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         hold           <= '0;
         full           <= 1'b0;
         rd             <= 1'b0;
         bus.o_10b      <= 10'h000;
         bus.o_valid    <= 1'b0;
         bus.o_idle     <= 1'b0;
         bus.o_code_err <= 1'b0;
      end else begin
         if (accept) begin
            hold.data <= bus.i_8b;
            hold.ctrl <= bus.i_ctrl;
         end
         full           <= accept || (full && !bus.i_en);
         bus.o_valid    <= bus.i_en;
         bus.o_code_err <= bus.i_en && sel_err;
         if (bus.i_en) begin
            bus.o_10b  <= sym;
            bus.o_idle <= sel_idle;
            rd         <= rd_nxt;
         end
      end
   end

endmodule

// File: tb/tb_encoder_8b10b.sv
// Directed bench for encoder_8b10b: idle stream, table of hand-encoded symbols,
// back-to-back code error, throttled streaming and mid-stream reset.
module tb_encoder_8b10b;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   encoder_8b10b_if bus();

   encoder_8b10b #(.IDLE_K(8'hBC)) dut (
      .i_clk     (clk),
      .i_aresetn (rst_n),
      .bus       (bus)
   );

   typedef struct {
      logic [7:0] b;
      logic       ctrl;
      logic [9:0] sym;
      logic       disp;
      logic       err;
   } vec_t;

   vec_t vecs[16];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pb[4];
      logic [9:0] ps[4];
      int         q[$];
      int         k;
      int         e;
      bit         mfull;
      bit         en;
      bit         acc;

      // Chained from RD- after the idle phase; each entry's RD follows the previous one.
      vecs[0]  = '{8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0}; // D0.0  RD-
      vecs[1]  = '{8'hB5, 1'b0, 10'h155, 1'b0, 1'b0}; // D21.5 RD-
      vecs[2]  = '{8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0}; // D17.7 RD- alt A7
      vecs[3]  = '{8'hB5, 1'b0, 10'h155, 1'b1, 1'b0}; // D21.5 RD+
      vecs[4]  = '{8'h00, 1'b0, 10'h346, 1'b1, 1'b0}; // D0.0  RD+
      vecs[5]  = '{8'hBC, 1'b1, 10'h283, 1'b0, 1'b0}; // K28.5 RD+
      vecs[6]  = '{8'h00, 1'b1, 10'h17C, 1'b1, 1'b1}; // illegal K at RD-
      vecs[7]  = '{8'hEB, 1'b0, 10'h04B, 1'b0, 1'b0}; // D11.7 RD+ alt A7
      vecs[8]  = '{8'h63, 1'b0, 10'h0E3, 1'b0, 1'b0}; // D3.3  RD-
      vecs[9]  = '{8'h1C, 1'b1, 10'h0BC, 1'b0, 1'b0}; // K28.0 RD-
      vecs[10] = '{8'hF7, 1'b1, 10'h057, 1'b0, 1'b0}; // K23.7 RD-
      vecs[11] = '{8'h27, 1'b0, 10'h247, 1'b0, 1'b0}; // D7.1  RD-
      vecs[12] = '{8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0}; // D17.7 RD-
      vecs[13] = '{8'h27, 1'b0, 10'h278, 1'b1, 1'b0}; // D7.1  RD+
      vecs[14] = '{8'hEE, 1'b0, 10'h04E, 1'b0, 1'b0}; // D14.7 RD+ alt A7
      vecs[15] = '{8'hFC, 1'b1, 10'h07C, 1'b0, 1'b0}; // K28.7 RD-

      pb = '{8'hB5, 8'h4A, 8'h23, 8'hC5};
      ps = '{10'h155, 10'h2AA, 10'h263, 10'h1A5};

      bus.i_en    = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_8b    = 8'h00;
      bus.i_ctrl  = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_10b",   bus.o_10b, 10'h000);
      chk("rst_valid", bus.o_valid, 1'b0);
      chk("rst_disp",  bus.o_disp, 1'b0);
      chk("rst_idle",  bus.o_idle, 1'b0);
      chk("rst_err",   bus.o_code_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", bus.o_ready, 1'b1);

      // Idle stream alternates K28.5 polarities
      bus.i_en = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("idle_sym",   bus.o_10b, (i % 2) ? 10'h283 : 10'h17C);
         chk("idle_disp",  bus.o_disp, (i % 2) ? 1'b0 : 1'b1);
         chk("idle_flag",  bus.o_idle, 1'b1);
         chk("idle_valid", bus.o_valid, 1'b1);
         if (i < 3) step();
      end
      bus.i_en = 1'b0;
      step();
      chk("hold_valid", bus.o_valid, 1'b0);
      chk("hold_sym",   bus.o_10b, 10'h283);

      for (int v = 0; v < 16; v++) begin
         bus.i_valid = 1'b1;
         bus.i_8b    = vecs[v].b;
         bus.i_ctrl  = vecs[v].ctrl;
         #1;
         chk("tbl_ready_empty", bus.o_ready, 1'b1);
         step();
         bus.i_valid = 1'b0;
         #1;
         chk("tbl_ready_full", bus.o_ready, 1'b0);
         bus.i_en = 1'b1;
         #1;
         chk("tbl_ready_en", bus.o_ready, 1'b1);
         step();
         chk("tbl_sym",   bus.o_10b, vecs[v].sym);
         chk("tbl_disp",  bus.o_disp, vecs[v].disp);
         chk("tbl_err",   bus.o_code_err, vecs[v].err);
         chk("tbl_idle",  bus.o_idle, 1'b0);
         chk("tbl_valid", bus.o_valid, 1'b1);
         bus.i_en = 1'b0;
      end

      // Illegal K accepted while an idle goes out, then error pulse, then idle again
      bus.i_en    = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_8b    = 8'h00;
      bus.i_ctrl  = 1'b1;
      step();
      bus.i_valid = 1'b0;
      bus.i_ctrl  = 1'b0;
      chk("seq_idle_sym",  bus.o_10b, 10'h17C);
      chk("seq_idle_flag", bus.o_idle, 1'b1);
      step();
      chk("seq_err_sym",   bus.o_10b, 10'h283);
      chk("seq_err_pulse", bus.o_code_err, 1'b1);
      chk("seq_err_idle",  bus.o_idle, 1'b0);
      chk("seq_err_disp",  bus.o_disp, 1'b0);
      step();
      chk("seq_after_sym",  bus.o_10b, 10'h17C);
      chk("seq_after_err",  bus.o_code_err, 1'b0);
      chk("seq_after_idle", bus.o_idle, 1'b1);
      step();
      chk("seq_back_sym", bus.o_10b, 10'h283);

      // Throttled stream: i_en every 4th cycle, source always valid
      k     = 0;
      mfull = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         en          = (cyc % 4 == 3);
         bus.i_en    = en;
         bus.i_valid = 1'b1;
         bus.i_8b    = pb[k % 4];
         bus.i_ctrl  = 1'b0;
         #1;
         acc = !mfull || en;
         chk("thr_ready", bus.o_ready, acc);
         if (acc) begin
            q.push_back(k);
            k++;
         end
         mfull = acc || (mfull && !en);
         step();
         if (en) begin
            chk("thr_valid", bus.o_valid, 1'b1);
            chk("thr_idle",  bus.o_idle, 1'b0);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("thr_sym", bus.o_10b, ps[e % 4]);
            end else begin
               chk("thr_queue_empty", 32'd1, 32'd0);
            end
         end else begin
            chk("thr_novalid", bus.o_valid, 1'b0);
         end
      end

      // Reset with an entry held and the source still valid
      bus.i_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_10b",   bus.o_10b, 10'h000);
      chk("mid_rst_valid", bus.o_valid, 1'b0);
      chk("mid_rst_disp",  bus.o_disp, 1'b0);
      chk("mid_rst_idle",  bus.o_idle, 1'b0);
      chk("mid_rst_err",   bus.o_code_err, 1'b0);
      bus.i_valid = 1'b0;
      bus.i_en    = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ready", bus.o_ready, 1'b1);
      step();
      chk("post_rst_sym",   bus.o_10b, 10'h17C);
      chk("post_rst_idle",  bus.o_idle, 1'b1);
      chk("post_rst_disp",  bus.o_disp, 1'b1);
      chk("post_rst_valid", bus.o_valid, 1'b1);
      bus.i_en = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/encoder_8b10b.md
# encoder_8b10b

Registered 8b/10b transmit encoder with running-disparity tracking, a one-entry input holding register and automatic comma (idle) insertion. Sits between the link-layer framer and the serializer. Emits one 10-bit symbol per symbol-enable strobe and is bit-compatible with the team's receive-side 8b/10b decoder.

## Interface

- IDLE_K, 8'hBC: control byte emitted when no data is pending, and substituted for invalid K requests (default K28.5).
- i_clk  input  1  clock; all state on rising edge.
- i_aresetn  input  1  asynchronous, active-low reset.
- i_en  input  1  symbol strobe; one output symbol is produced per cycle with i_en=1.
- i_8b  input  8  byte HGFEDCBA, A = bit 0.
- i_ctrl  input  1  1 = encode i_8b as K code, 0 = D code.
- i_valid  input  1  i_8b/i_ctrl valid.
- o_ready  output  1  holding register can accept.
- o_10b  output  10  symbol, o_10b[0]=a … [5]=i, [6]=f … [9]=j; bit 0 transmitted first.
- o_valid  output  1  one-cycle pulse: o_10b updated this cycle.
- o_disp  output  1  running disparity after o_10b (0 = RD−, 1 = RD+).
- o_idle  output  1  o_10b is an inserted IDLE_K symbol.
- o_code_err  output  1  one-cycle pulse: invalid K request replaced by IDLE_K.

## Operation

- Holding register: one entry {byte, ctrl}, flag `full`.
- o_ready = !full | i_en (combinational). Accept when i_valid & o_ready.
- On cycle with i_en=1:
  - if full: encode held entry, register into o_10b; o_idle=0.
  - else: encode IDLE_K as K; o_idle=1.
  - o_valid=1; RD updated; full cleared unless a new entry is accepted in the same cycle (then full stays 1 with the new entry).
- No bypass: an entry accepted in cycle N is emitted no earlier than the next i_en cycle after N.
- i_en=0: o_10b, o_disp, o_idle hold; o_valid=0; accept still allowed while !full.
- Encoding: standard 5b/6b (EDCBA→abcdei) then 3b/4b (HGF→fghj).
  - 5b/6b selected by current RD; RD after 6b sub-block (flips if unbalanced) selects 4b code.
  - D.x.7: alternate A7 (0111/1000) when RD− and x∈{17,18,20}, or RD+ and x∈{11,13,14}.
  - Valid K: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. Any other byte with ctrl=1: emit IDLE_K instead, o_code_err=1 for that symbol, o_idle=0.
  - RD after symbol: flips on each unbalanced sub-block; stored in o_disp.
- Reset (async assert, any time incl. mid-stream): full=0, RD=RD−, o_10b=10'h000, o_valid=0, o_disp=0, o_idle=0, o_code_err=0. o_ready=1 once reset deasserted.

## Timing

- Symbol latency: registered; o_10b/o_valid change on the rising edge of a cycle with i_en=1, visible the following cycle.
- Throughput: one symbol per i_en; with i_en held high and i_valid high, one byte accepted and one emitted per cycle.
- o_code_err, o_valid: single-cycle pulses aligned with the o_10b they describe.
- o_ready has a combinational path from i_en only (no path from i_valid).

## Test plan

- Reset then i_en=1 continuously, i_valid=0 → o_10b alternates 10'h17C (RD−→+), 10'h283 (RD+→−), o_idle=1, o_disp 1,0,1….
- From RD−, send D0.0 (i_8b=8'h00, ctrl=0) → o_10b=10'h0B9, o_disp=0, o_idle=0; next idle is 10'h17C.
- From RD−, send D17.7 (8'hF1) → o_10b=10'h3B1 (A7 used), o_disp=1; next idle 10'h283.
- Send D21.5 (8'hB5) at RD− and at RD+ → both 10'h155, o_disp unchanged.
- Invalid K (i_8b=8'h00, ctrl=1) at RD− → o_10b=10'h17C, o_code_err=1 one cycle, o_disp=1.
- i_en=1 every 4th cycle, i_valid held high with incrementing bytes → o_ready low while full and no i_en, high on i_en cycles; no byte lost or duplicated; assert i_aresetn=0 mid-stream → all outputs to reset values immediately, first symbol after release is 10'h17C.
